// File: rtl/mul_iter.sv
// mul_iter - iterative (multi-cycle) integer multiplier.
//
// Retires BITS_PER_CYCLE multiplier bits per clock. The multiplier works on
// operand magnitudes and applies the product sign at the end. Operands are
// unsigned or two's complement, selected per transaction. Valid/ready
// handshakes are used on both the input and the output side.
//
// Parameters:
//   WIDTH          operand width; must be >= 4 and a multiple of BITS_PER_CYCLE
//   BITS_PER_CYCLE multiplier bits consumed per RUN cycle; 1, 2 or 4
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands presented
//   in_ready   block idle and able to accept operands
//   in_a       multiplicand (WIDTH)
//   in_b       multiplier (WIDTH)
//   in_signed  1: in_a/in_b are two's complement; 0: unsigned
//   out_valid  out_p holds a completed product
//   out_ready  consumer accepts out_p
//   out_p      exact product (2*WIDTH)
//
// Optional build macro:
//   MUL_ITER_EARLY_TERM_EN  finish as soon as the remaining multiplier bits
//                           are all zero. Result values are identical either
//                           way; only latency changes.

module mul_iter #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int unsigned K     = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(K + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q,     state_d;
    logic [PW-1:0]      mcand_q,     mcand_d;
    logic [WIDTH-1:0]   mplier_q,    mplier_d;
    logic [PW-1:0]      acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               neg_q,       neg_d;
    logic               out_valid_q, out_valid_d;
    logic [PW-1:0]      out_p_q,     out_p_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [PW-1:0]      partial;
    logic [PW-1:0]      acc_next;
    logic [PW-1:0]      mcand_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [PW-1:0]      result;
    logic               last_step;

    // Magnitudes. Negating the most-negative value wraps back to itself,
    // which read as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    always_comb begin
        a_mag = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        b_mag = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    end

    // One radix-2^BITS_PER_CYCLE step: shift-and-add over the low multiplier bits.
    always_comb begin
        partial = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
        acc_next    = acc_q + partial;
        mcand_next  = mcand_q << BITS_PER_CYCLE;
        mplier_next = mplier_q >> BITS_PER_CYCLE;
        // Two's-complement negate of a zero magnitude stays zero.
        result      = neg_q ? -acc_next : acc_next;
`ifdef MUL_ITER_EARLY_TERM_EN
        last_step   = (cnt_q == CNT_W'(1)) || (mplier_next == '0);
`else
        last_step   = (cnt_q == CNT_W'(1));
`endif
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    neg_d    = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CNT_W'(K);
                    state_d  = RUN;
                end
            end

            RUN: begin
                acc_d    = acc_next;
                mcand_d  = mcand_next;
                mplier_d = mplier_next;
                cnt_d    = cnt_q - CNT_W'(1);
                if (last_step) begin
                    out_p_d     = result;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                // out_p keeps its value after hand-off; only out_valid drops.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;

endmodule

// File: tb/tb_mul_iter.sv
module tb_mul_iter;

    localparam int unsigned W  = 32;
    localparam int unsigned B  = 2;
    localparam int unsigned K  = W / B;
    localparam int unsigned PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_signed;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_p;

    int n_checks = 0;
    int n_fail   = 0;

    mul_iter #(
        .WIDTH          (W),
        .BITS_PER_CYCLE (B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    always #5 clk = ~clk;

    // Reference product: sign/zero extend to 2W and multiply with plain arithmetic.
    function automatic logic [PW-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                 input logic s);
        logic signed [PW-1:0] xa;
        logic signed [PW-1:0] xb;
        if (s) begin
            xa = {{W{a[W-1]}}, a};
            xb = {{W{b[W-1]}}, b};
        end else begin
            xa = {{W{1'b0}}, a};
            xb = {{W{1'b0}}, b};
        end
        return xa * xb;
    endfunction

    // Reference latency in edges, counting the accepting edge.
`ifdef MUL_ITER_EARLY_TERM_EN
    function automatic int model_lat(input logic [W-1:0] b, input logic s);
        longint v;
        int     bl;
        int     steps;
        v = s ? longint'($signed(b)) : longint'({32'b0, b});
        if (v < 0) v = -v;
        bl = 0;
        while (v != 0) begin
            bl++;
            v = v / 2;
        end
        steps = (bl + B - 1) / B;
        if (steps < 1) steps = 1;
        return 1 + steps;
    endfunction
`else
    function automatic int model_lat(input logic [W-1:0] b, input logic s);
        if (s && b[0] === 1'bx) return 0;
        return K + 1;
    endfunction
`endif

    // Drives one transaction from IDLE, returns product and latency, takes the output.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [PW-1:0] p, output int lat);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < int'(K) + 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        p = out_p;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_p !== '0) begin n_fail++; $display("FAIL reset out_p: got %h expected 0", out_p); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post-reset in_ready: got %b expected 1", in_ready); end
    endtask

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        logic [PW-1:0] p;
    } vec_t;

    vec_t vecs [8] = '{
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001},
        '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE},
        '{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE},
        '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000},
        '{32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000},
        '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0000},
        '{32'hFFFF_FFF9, 32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000},
        '{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000}
    };

    task automatic test_directed();
        logic [PW-1:0] p;
        int            lat;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
            n_checks++;
            if (p !== vecs[i].p) begin
                n_fail++;
                $display("FAIL directed[%0d] product: got %h expected %h", i, p, vecs[i].p);
            end
            n_checks++;
            if (lat != model_lat(vecs[i].b, vecs[i].s)) begin
                n_fail++;
                $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat,
                         model_lat(vecs[i].b, vecs[i].s));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] exp_p;
        int            waited;
        exp_p     = 64'h0B00_EA4E_242D_2080;
        in_a      = 32'h1234_5678;
        in_b      = 32'h9ABC_DEF0;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Next request held on the bus while the block is busy.
        in_a = 32'd7;
        in_b = 32'd6;
        waited = 0;
        while (out_valid !== 1'b1 && waited < int'(K) + 10) begin
            @(posedge clk); #1;
            waited++;
        end
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_p !== exp_p || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure hold cycle %0d: got valid=%b p=%h ready=%b expected valid=1 p=%h ready=0",
                         c, out_valid, out_p, in_ready, exp_p);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== exp_p) begin
            n_fail++;
            $display("FAIL backpressure release: got valid=%b ready=%b p=%h expected valid=0 ready=1 p=%h",
                     out_valid, in_ready, out_p, exp_p);
        end
        // Held request is accepted on the following edge, not lost.
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL held request accept: in_ready got %b expected 0", in_ready); end
        waited = 0;
        while (out_valid !== 1'b1 && waited < int'(K) + 10) begin
            @(posedge clk); #1;
            waited++;
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_p !== 64'd42) begin
            n_fail++;
            $display("FAIL held request product: got valid=%b p=%h expected valid=1 p=%h", out_valid, out_p, 64'd42);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [PW-1:0] p;
        int            lat;
        bit            seen;
        in_a      = 32'hFFFF_FFFF;
        in_b      = 32'hFFFF_FFFF;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_p !== '0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async reset: got valid=%b p=%h ready=%b expected valid=0 p=0 ready=1",
                     out_valid, out_p, in_ready);
        end
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < int'(K) + 4; c++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL discarded product emitted: got out_valid=1 expected 0"); end
        run_op(32'd3, 32'd5, 1'b0, p, lat);
        n_checks++;
        if (p !== 64'd15) begin n_fail++; $display("FAIL after reset 3*5: got %h expected %h", p, 64'd15); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        int            t_seen [$];
        logic [PW-1:0] p_seen [$];
        int            guard;
        a = $urandom;
        b = $urandom | 32'h8000_0000;
        s = 1'b0;
        in_a = a; in_b = b; in_signed = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 1; e <= 3 * (int'(K) + 2) + 4; e++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                t_seen.push_back(e);
                p_seen.push_back(out_p);
            end
        end
        in_valid = 1'b0;
        guard = 0;
        while (in_ready !== 1'b1 && guard < int'(K) + 10) begin
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (t_seen.size() < 3) begin
            n_fail++;
            $display("FAIL back_to_back count: got %0d outputs expected at least 3", t_seen.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (p_seen[i] !== model_prod(a, b, s)) begin
                    n_fail++;
                    $display("FAIL back_to_back product %0d: got %h expected %h", i, p_seen[i], model_prod(a, b, s));
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (t_seen[i] - t_seen[i-1] != model_lat(b, s) + 1) begin
                    n_fail++;
                    $display("FAIL back_to_back period %0d: got %0d expected %0d", i,
                             t_seen[i] - t_seen[i-1], model_lat(b, s) + 1);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          s;
        logic [PW-1:0] p;
        int            lat;
        logic [W-1:0]  corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'hFFFF_FFFF;
        for (int n = 0; n < 1500; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) b = corner[$urandom_range(0, 3)];
            run_op(a, b, s, p, lat);
            n_checks++;
            if (p !== model_prod(a, b, s)) begin
                n_fail++;
                $display("FAIL random[%0d] %h*%h s=%b: got %h expected %h", n, a, b, s, p, model_prod(a, b, s));
            end
            n_checks++;
            if (lat != model_lat(b, s)) begin
                n_fail++;
                $display("FAIL random[%0d] latency b=%h s=%b: got %0d expected %0d", n, b, s, lat, model_lat(b, s));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_iter.md
Name: mul_iter

Overview:
- Parametrised iterative (multi-cycle) integer multiplier; sequential successor to the combinational 32x32 array multiplier.
- Retires BITS_PER_CYCLE multiplier bits per clock.
- Supports unsigned and two's-complement signed operands, selected per transaction.
- Valid/ready handshakes on input and output; used where area matters more than single-cycle latency.

Parameters:
- WIDTH, 32, operand width in bits. Must be ≥ 4 and a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 2, multiplier bits consumed per RUN cycle. Legal values: 1, 2, 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operand presented.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = treat in_a/in_b as two's complement; 0 = unsigned.
- out_valid  out  1  out_p holds a completed product.
- out_ready  in  1  consumer accepts out_p.
- out_p  out  2*WIDTH  exact product.

Behaviour:
- Reset (asynchronous, active-high, any state, including mid-operation):
  - state=IDLE; out_valid=0; out_p=0; accumulator, counter and sign flag cleared.
  - An in-flight product is discarded and never emitted.
- in_ready = (state==IDLE), combinational. It is 1 during and after reset.
- Define K = WIDTH/BITS_PER_CYCLE.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE:
    - Accept on a rising edge with in_valid&&in_ready.
    - Capture mcand=|in_a| and mplier=|in_b| (magnitudes only when in_signed=1; raw otherwise).
    - Capture neg = in_signed & (in_a[MSB]^in_b[MSB]).
    - acc=0; cnt=K; go to RUN. Without in_valid, remain in IDLE.
  - RUN, each edge:
    - acc += mcand * mplier[BITS_PER_CYCLE-1:0].
    - mcand <<= BITS_PER_CYCLE (in a 2*WIDTH register); mplier >>= BITS_PER_CYCLE; cnt--.
    - On the edge where cnt goes 1 -> 0: register out_p = neg ? -acc_next : acc_next (2*WIDTH two's complement); set out_valid=1; go to DONE.
    - in_valid is ignored.
  - DONE:
    - out_valid=1; out_p held stable until the edge with out_ready=1.
    - On that edge: out_valid=0, go to IDLE. out_p keeps its last value.
    - No back-to-back overlap: a new input is not accepted in the same edge the output is taken.
- Latency: out_valid rises on the (K+1)th rising edge counting the accepting edge. Defaults: K=16, latency 17 edges.
- Throughput: one product per K+2 cycles when out_ready is held 1.
- Arithmetic and boundary cases:
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned in WIDTH bits. The most-negative operand must produce the exact product; (-2^31)*(-2^31) = 64'h4000_0000_0000_0000.
  - Zero operands with neg=1 produce 0, never negative zero issues (-0 = 0).
  - The accumulator never overflows 2*WIDTH bits.
- in_valid held high while in_ready=0: inputs are not sampled and no transaction is lost. The source must hold its operands.

Optional Feature:
- Macro MUL_ITER_EARLY_TERM_EN.
- Defined:
  - In RUN, if the shifted mplier after the current step is zero, complete on that edge: register out_p and go to DONE regardless of cnt.
  - Latency becomes 1 + max(1, ceil(bitlen(|in_b|)/BITS_PER_CYCLE)) edges.
  - Example: b=0 or b=1 gives latency 2.
- Undefined: latency is fixed at K+1 for every operand. Result values are identical in both builds.

Test Plan:
- Unsigned, in_a=32'hFFFF_FFFF, in_b=32'hFFFF_FFFF, out_ready=1 -> out_p=64'hFFFF_FFFE_0000_0001. out_valid rises exactly 17 edges after accept (no macro).
- Signed, in_a=32'hFFFF_FFFF (-1), in_b=32'h0000_0002 -> out_p=64'hFFFF_FFFF_FFFF_FFFE. Same inputs unsigned -> 64'h0000_0001_FFFF_FFFE.
- Signed, in_a=in_b=32'h8000_0000 -> out_p=64'h4000_0000_0000_0000. Signed 32'h8000_0000 * 32'h1 -> 64'hFFFF_FFFF_8000_0000.
- Backpressure: complete 32'h1234_5678*32'h9ABC_DEF0 with out_ready=0 for 10 cycles -> out_p=64'h0B00_EA4E_242D_2080 stable, out_valid=1, in_ready=0 throughout. Pulse out_ready -> IDLE next edge.
- Assert rst for one cycle at RUN cycle 5 -> out_valid=0 and out_p=0 immediately (asynchronous). No product is emitted. The next transaction 3*5 returns 15.
- Random: 100k {a, b, in_signed} triples against a 64-bit golden model, BITS_PER_CYCLE in {1,2,4}, with and without MUL_ITER_EARLY_TERM_EN -> zero mismatches. Latency matches the formula for each build.
